// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle main control unit and the ALU control block.
package cpu_ctrl_pkg;

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_IMM_EXEC  = 4'd10;
    localparam logic [3:0] S_IMM_WB    = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_ORI   = 2'b11;

    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_J) || (op == OP_ADDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/main_control_fsm.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/write-back from the
// opcode, drives all datapath enables and selects, and counts retired instructions.
module main_control_fsm
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic [3:0]  state,
    output logic        illegal_op,
    output logic [31:0] instr_retired
);

    logic [3:0]  state_q, state_d;
    logic [5:0]  op_q;
    logic [31:0] retired_q;
    logic        retire;

    always_comb begin
        state_d = S_FETCH;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:     state_d = S_MEM_ADDR;
                    OP_RTYPE:         state_d = S_EXECUTE;
                    OP_BEQ:           state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    OP_ADDI, OP_ORI:  state_d = S_IMM_EXEC;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: begin
                state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
                retire  = mem_ready;
            end
            S_EXECUTE:   state_d = S_R_WB;
            S_IMM_EXEC:  state_d = S_IMM_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_IMM_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:     state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= 6'd0;
            retired_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
            // Written only on retirement so the value otherwise holds untouched.
            if (retire) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        alu_op        = ALU_ADD;
        pc_source     = PC_SRC_ALU;
        illegal_op    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                // Gate with reset so IR/PC never load while held in reset.
                ir_write  = mem_ready & rst_n;
                pc_write  = mem_ready & rst_n;
            end
            S_DECODE: begin
                alu_src_b  = SRC_B_IMM_SH2;
                illegal_op = !is_legal_op(opcode);
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_SRC_JUMP;
            end
            S_IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                alu_op    = (op_q == OP_ORI) ? ALU_ORI : ALU_ADD;
            end
            S_IMM_WB: reg_write = 1'b1;
            default: ;
        endcase
    end

    assign state         = state_q;
    assign instr_retired = retired_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Randomized and directed bench for main_control_fsm against a route-based behavioural model.
module tb_main_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
    logic        reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [31:0] instr_retired;

    int checks = 0;
    int failures = 0;
    logic preload = 1'b0;

    main_control_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .state         (state),
        .illegal_op    (illegal_op),
        .instr_retired (instr_retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_state = 0;
    logic [5:0]  m_op = 6'd0;
    logic [31:0] m_ret = 32'd0;
    int          route[$];

    function automatic logic legal(input logic [5:0] op);
        return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
               op == 6'h02 || op == 6'h08 || op == 6'h0D;
    endfunction

    // Remaining states after DECODE for each instruction class.
    always @(posedge clk or negedge rst_n or posedge preload) begin
        if (!rst_n) begin
            m_state = 0;
            m_op    = 6'd0;
            m_ret   = 32'd0;
            route.delete();
        end else if (preload) begin
            m_ret = 32'hFFFF_FFFF;
        end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
            m_state = m_state;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            m_op = opcode;
            case (opcode)
                6'h23:        route = '{2, 3, 4};
                6'h2B:        route = '{2, 5};
                6'h00:        route = '{6, 7};
                6'h04:        route = '{8};
                6'h02:        route = '{9};
                6'h08, 6'h0D: route = '{10, 11};
                default:      route.delete();
            endcase
            if (route.size() == 0) m_state = 0;
            else m_state = route.pop_front();
        end else if (route.size() == 0) begin
            m_state = 0;
            m_ret   = m_ret + 32'd1;
        end else begin
            m_state = route.pop_front();
        end
    end

    // {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst,
    //  mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op}
    function automatic logic [16:0] exp_out(input int s, input logic [5:0] op, input logic mr,
                                            input logic rn, input logic [5:0] opc);
        logic pw, pwc, irw, iod, mrd, mwr, rw, rd, m2r, sa, ill;
        logic [1:0] sb, ao, ps;
        {pw, pwc, irw, iod, mrd, mwr, rw, rd, m2r, sa, ill} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (s)
            0:  begin mrd = 1; sb = 2'b01; irw = mr & rn; pw = mr & rn; end
            1:  begin sb = 2'b11; ill = !legal(opc); end
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mrd = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iod = 1; end
            6:  begin sa = 1; ao = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
            9:  begin pw = 1; ps = 2'b10; end
            10: begin sa = 1; sb = 2'b10; ao = (op == 6'h0D) ? 2'b11 : 2'b00; end
            11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, irw, iod, mrd, mwr, rw, rd, m2r, sa, sb, ao, ps, ill};
    endfunction

    always @(negedge clk) begin
        chk("outputs", {15'd0, pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
                        reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                        pc_source, illegal_op},
            {15'd0, exp_out(m_state, m_op, mem_ready, rst_n, opcode)});
        chk("state", {28'd0, state}, m_state);
        chk("instr_retired", instr_retired, m_ret);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, output int cyc, output int ill,
                             output int pwc, output logic [1:0] exec_op);
        cyc = 0; ill = 0; pwc = 0; exec_op = 2'bxx;
        opcode = op;
        mem_ready = 1'b1;
        do begin
            if (illegal_op) ill++;
            if (pc_write_cond && pc_source == 2'b01) pwc++;
            if (state == 4'd6 || state == 4'd10) exec_op = alu_op;
            step();
            cyc++;
        end while (state != 4'd0 && cyc < 50);
    endtask

    int cyc, ill, pwc, cnt_mw, cnt_rw, stall, rdst;
    logic [1:0] eop;
    int lw_seq[6] = '{0, 1, 2, 3, 4, 0};
    logic [5:0] ops[7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0D};

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'h00;
        repeat (3) step();
        chk("reset state", {28'd0, state}, 32'd0);
        chk("reset counter", instr_retired, 32'd0);
        chk("reset ir_write", {31'd0, ir_write}, 32'd0);
        chk("reset pc_write", {31'd0, pc_write}, 32'd0);
        chk("reset mem_read", {31'd0, mem_read}, 32'd1);
        chk("reset alu_src_b", {30'd0, alu_src_b}, 32'd1);
        rst_n = 1'b1;

        // lw, mem_ready high
        opcode = 6'h23;
        for (int i = 0; i < 6; i++) begin
            chk("lw state seq", {28'd0, state}, lw_seq[i]);
            if (state == 4'd4) chk("lw wb strobes", {30'd0, reg_write, mem_to_reg}, 32'd3);
            if (i < 5) step();
        end
        chk("lw counter", instr_retired, 32'd1);

        // sw with three stall cycles in MEM_WRITE
        opcode = 6'h2B; cyc = 0; cnt_mw = 0; cnt_rw = 0; stall = 3;
        do begin
            if (state == 4'd5 && stall > 0) begin mem_ready = 1'b0; stall--; end
            else mem_ready = 1'b1;
            #1;
            if (mem_write && i_or_d) cnt_mw++;
            if (reg_write) cnt_rw++;
            step();
            cyc++;
        end while (state != 4'd0 && cyc < 50);
        chk("sw cycles", cyc, 32'd7);
        chk("sw mem_write cycles", cnt_mw, 32'd4);
        chk("sw reg_write cycles", cnt_rw, 32'd0);
        chk("sw counter", instr_retired, 32'd2);

        // R-type then ori
        run_instr(6'h00, cyc, ill, pwc, eop);
        chk("rtype cycles", cyc, 32'd4);
        chk("rtype alu_op", {30'd0, eop}, 32'd2);
        run_instr(6'h0D, cyc, ill, pwc, eop);
        chk("ori cycles", cyc, 32'd4);
        chk("ori alu_op", {30'd0, eop}, 32'd3);
        chk("rtype+ori counter", instr_retired, 32'd4);

        // illegal opcode
        run_instr(6'h3F, cyc, ill, pwc, eop);
        chk("illegal cycles", cyc, 32'd2);
        chk("illegal pulses", ill, 32'd1);
        chk("illegal counter", instr_retired, 32'd4);

        // async reset in MEM_READ
        opcode = 6'h23; mem_ready = 1'b1; cyc = 0;
        while (state != 4'd3 && cyc < 20) begin
            step();
            cyc++;
        end
        mem_ready = 1'b0;
        step();
        chk("stalled in mem_read", {28'd0, state}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset state", {28'd0, state}, 32'd0);
        chk("async reset counter", instr_retired, 32'd0);
        step();
        rst_n = 1'b1;
        run_instr(6'h04, cyc, ill, pwc, eop);
        chk("beq cycles", cyc, 32'd3);
        chk("beq pc_write_cond", pwc, 32'd1);
        chk("beq counter", instr_retired, 32'd1);

        // counter wrap
        preload = 1'b1;
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        preload = 1'b0;
        run_instr(6'h02, cyc, ill, pwc, eop);
        chk("j cycles", cyc, 32'd3);
        chk("wrap counter", instr_retired, 32'd0);
        run_instr(6'h08, cyc, ill, pwc, eop);
        chk("addi cycles", cyc, 32'd4);
        chk("addi alu_op", {30'd0, eop}, 32'd0);

        // random traffic; the per-cycle compare process checks everything
        rdst = 0;
        for (int i = 0; i < 3000; i++) begin
            mem_ready = ($urandom % 4) != 0;
            if ($urandom % 8 == 0) opcode = 6'($urandom);
            else opcode = ops[$urandom % 7];
            if ($urandom % 400 == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
